// File: rtl/instruction_fetch.sv
// Instruction fetch stage: PC register, next-PC select and the IF/ID pipeline register.
// Optional FETCH_ALIGN_CHECK_EN adds a sticky flag for misaligned jr targets.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [15:0] branch_offset,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic        jr,
  input  logic [31:0] jr_target,
  output logic        if_id_valid,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        fetch_misalign
);

  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] branch_target;
  logic [31:0] jump_target;
  logic [31:0] jr_aligned;
  logic [31:0] redirect_target;
  logic        redirect;

  assign imem_addr = pc;
  assign pc_plus4  = pc + 32'd4;

  // Targets are relative to the instruction sitting in IF/ID, not the one being fetched.
  assign branch_target = if_id_pc4 + {{14{branch_offset[15]}}, branch_offset, 2'b00};
  assign jump_target   = {if_id_pc4[31:28], jump_index, 2'b00};
  assign jr_aligned    = {jr_target[31:2], 2'b00};

  always_comb begin
    redirect_target = branch_target;
    if (jr) begin
      redirect_target = jr_aligned;
    end else if (jump) begin
      redirect_target = jump_target;
    end
  end

  // A bubble in IF/ID cannot own a redirect, so requests are only honoured behind a valid instruction.
  assign redirect = if_id_valid && !stall && (jr || jump || branch_taken);

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc          <= RESET_PC;
      if_id_valid <= 1'b0;
      if_id_instr <= 32'h0000_0000;
      if_id_pc4   <= 32'h0000_0000;
    end else if (!stall) begin
      if (redirect) begin
        pc          <= redirect_target;
        if_id_valid <= 1'b0;
        if_id_instr <= 32'h0000_0000;
        if_id_pc4   <= pc_plus4;
      end else begin
        pc          <= pc_plus4;
        if_id_valid <= 1'b1;
        if_id_instr <= imem_data;
        if_id_pc4   <= pc_plus4;
      end
    end
  end

`ifdef FETCH_ALIGN_CHECK_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_misalign <= 1'b0;
    end else if (redirect && jr && (jr_target[1:0] != 2'b00)) begin
      fetch_misalign <= 1'b1;
    end
  end
`else
  logic unused_jr_low;
  assign unused_jr_low  = ^jr_target[1:0];
  assign fetch_misalign = 1'b0;
`endif

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, PC value loaded on reset.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-low reset.
REQ-004 imem_addr  out  32  current PC, drives instruction-memory Address.
REQ-005 imem_data  in  32  instruction returned combinationally for imem_addr.
REQ-006 stall  in  1  hold PC and IF/ID register.
REQ-007 branch_taken  in  1  redirect to branch target.
REQ-008 branch_offset  in  16  signed word offset of the decoded branch.
REQ-009 jump  in  1  redirect to J-type target (j/jal).
REQ-010 jump_index  in  26  J-type instr_index field.
REQ-011 jr  in  1  redirect to register target.
REQ-012 jr_target  in  32  register value for jr.
REQ-013 if_id_valid  out  1  IF/ID register holds a real instruction.
REQ-014 if_id_instr  out  32  latched instruction.
REQ-015 if_id_pc4  out  32  PC+4 of the latched instruction.
REQ-016 fetch_misalign  out  1  sticky misaligned-target flag (see Configuration).

Function
REQ-017 The block SHALL hold a 32-bit PC register; imem_addr SHALL equal PC combinationally.
REQ-018 Redirect targets SHALL use if_id_pc4: branch = if_id_pc4 + (sign_extend(branch_offset) << 2), modulo 2^32; jump = {if_id_pc4[31:28], jump_index, 2'b00}; jr = {jr_target[31:2], 2'b00}.
REQ-019 Next-PC priority SHALL be stall (hold) > jr > jump > branch_taken > PC+4.
REQ-020 Redirect inputs SHALL be ignored while stall=1; the producer holds them until stall deasserts.
REQ-021 PC+4 SHALL wrap: 32'hFFFF_FFFC -> 32'h0000_0000.
REQ-022 Non-stall, non-redirect cycle: IF/ID SHALL load {valid=1, instr=imem_data, pc4=PC+4}.
REQ-023 Redirect cycle (no stall): IF/ID SHALL load valid=0, instr=32'h0000_0000 (wrong-path squash, no delay slot), and PC SHALL load the target.
REQ-024 Stall cycle: PC, if_id_valid, if_id_instr and if_id_pc4 SHALL hold unchanged.
REQ-025 Fetch-to-decode latency SHALL be exactly one cycle; redirect penalty SHALL be exactly one bubble.
REQ-026 Redirect inputs SHALL take effect only when if_id_valid=1; they are ignored otherwise.

Reset
REQ-027 With reset=0 at a rising edge: PC=RESET_PC, if_id_valid=0, if_id_instr=0, if_id_pc4=0, fetch_misalign=0; reset SHALL override stall and all redirects.
REQ-028 Mid-operation reset SHALL discard any pending redirect; the first valid fetch SHALL be at RESET_PC in the cycle after reset deasserts.

Configuration
REQ-029 Macro FETCH_ALIGN_CHECK_EN defined: an accepted jr with jr_target[1:0]!=0 SHALL set fetch_misalign=1 (sticky until reset); PC still loads the aligned address.
REQ-030 Macro undefined: jr_target[1:0] SHALL be dropped silently, and fetch_misalign SHALL be tied to 0.

Verification
REQ-031 Reset release with RESET_PC=0, no stalls -> imem_addr 0x0, 0x4, 0x8 on successive cycles; if_id_pc4 trails by one cycle; if_id_valid=1 from the second cycle.
REQ-032 if_id_pc4=0x0C, branch_taken=1, branch_offset=16'hFFFF -> next imem_addr=0x08; if_id_valid=0 for one cycle.
REQ-033 if_id_pc4=0x08, jump=1, jump_index=26'h3 (with branch_taken=1 simultaneously) -> imem_addr=0x0C; jump wins.
REQ-034 jr=1, jr_target=0x31 -> imem_addr=0x30; fetch_misalign=1 with FETCH_ALIGN_CHECK_EN defined, and 0 without it.
REQ-035 stall=1 for 2 cycles at PC=0x10 while branch_taken=1 -> PC stays 0x10 and IF/ID is unchanged; after stall drops, branch is taken.
REQ-036 PC=0xFFFF_FFFC, no redirect -> next PC=0x0; reset=0 asserted during a jr -> PC=RESET_PC and if_id_valid=0.
